// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared definitions for the MultiCycleCPU control unit.
//   - opcode constants (IR[31:26])
//   - FSM state encodings
//   - ALUOp / PCSrc / RegDst encodings
//   - the control word produced by mcpu_decode
//   - small opcode classification helpers used by decode and next-state logic
package mcpu_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_M = 3'b010,
    S_MEM   = 3'b011,
    S_WB_M  = 3'b100,
    S_EXE_B = 3'b101,
    S_EXE_R = 3'b110,
    S_WB_R  = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b110
  } aluop_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_RS     = 2'b10,
    PC_JUMP   = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    RD_RA = 2'b00,
    RD_RT = 2'b01,
    RD_RD = 2'b10
  } regdst_t;

  typedef struct packed {
    logic    pcwre;
    logic    irwre;
    logic    insmemrw;
    logic    regwre;
    logic    alusrca;
    logic    alusrcb;
    logic    dbdatasrc;
    logic    wrregdsrc;
    logic    mrd;
    logic    mwr;
    logic    extsel;
    regdst_t regdst;
    pcsrc_t  pcsrc;
    aluop_t  aluop;
  } ctrl_t;

  // Opcodes outside this list behave exactly like halt.
  function automatic logic op_defined(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLT,
      OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR, OP_JAL,
      OP_HALT: op_defined = 1'b1;
      default: op_defined = 1'b0;
    endcase
  endfunction

  function automatic logic op_jump(input logic [5:0] op);
    op_jump = (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  endfunction

  function automatic logic op_branch(input logic [5:0] op);
    op_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

  function automatic logic op_mem(input logic [5:0] op);
    op_mem = (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_imm(input logic [5:0] op);
    op_imm = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) ||
             (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mcpu_decode.sv
// mcpu_decode: combinational control-word decode for the multicycle CPU.
// Ports:
//   state  - current FSM state
//   opcode - IR[31:26]
//   zero   - ALU result == 0 (branch condition)
//   sign   - ALU result[31]  (bltz condition)
//   ctrl   - full control word for the datapath in this cycle
module mcpu_decode
  import mcpu_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.insmemrw = 1'b1;
    ctrl.regdst   = RD_RA;
    ctrl.pcsrc    = PC_NEXT;
    ctrl.aluop    = ALU_ADD;

    // In IF the IR still holds the previous instruction, so the ALU-side
    // selects are left at their defaults there; from ID onward they follow
    // the opcode, which keeps ALUOp stable through EXE and MEM/WB.
    if (state != S_IF) begin
      ctrl.alusrca = (opcode == OP_SLL);
      ctrl.alusrcb = op_imm(opcode) || op_mem(opcode);
      ctrl.extsel  = !((opcode == OP_ANDI) || (opcode == OP_ORI));
      case (opcode)
        OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ctrl.aluop = ALU_SUB;
        OP_ORI:                          ctrl.aluop = ALU_OR;
        OP_AND, OP_ANDI:                 ctrl.aluop = ALU_AND;
        OP_SLT, OP_SLTI:                 ctrl.aluop = ALU_SLT;
        OP_SLL:                          ctrl.aluop = ALU_SLL;
        default:                         ctrl.aluop = ALU_ADD;
      endcase
    end

    case (state)
      S_IF: begin
        ctrl.irwre = 1'b1;
      end
      S_ID: begin
        // Jumps complete in ID; jal links PC+4 into $31 in the same cycle.
        if (op_jump(opcode)) begin
          ctrl.pcwre = 1'b1;
          ctrl.pcsrc = (opcode == OP_JR) ? PC_RS : PC_JUMP;
          if (opcode == OP_JAL) begin
            ctrl.regwre    = 1'b1;
            ctrl.regdst    = RD_RA;
            ctrl.wrregdsrc = 1'b0;
          end
        end
      end
      S_EXE_B: begin
        ctrl.pcwre = 1'b1;
        case (opcode)
          OP_BEQ:  ctrl.pcsrc = zero ? PC_BRANCH : PC_NEXT;
          OP_BNE:  ctrl.pcsrc = zero ? PC_NEXT : PC_BRANCH;
          OP_BLTZ: ctrl.pcsrc = sign ? PC_BRANCH : PC_NEXT;
          default: ctrl.pcsrc = PC_NEXT;
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LW) begin
          ctrl.mrd       = 1'b1;
          ctrl.dbdatasrc = 1'b1;
        end else begin
          ctrl.mwr   = 1'b1;
          ctrl.pcwre = 1'b1;
        end
      end
      S_WB_R: begin
        ctrl.pcwre     = 1'b1;
        ctrl.regwre    = 1'b1;
        ctrl.wrregdsrc = 1'b1;
        ctrl.regdst    = op_imm(opcode) ? RD_RT : RD_RD;
      end
      S_WB_M: begin
        ctrl.pcwre     = 1'b1;
        ctrl.regwre    = 1'b1;
        ctrl.wrregdsrc = 1'b1;
        ctrl.dbdatasrc = 1'b1;
        ctrl.regdst    = RD_RT;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: control FSM sequencing the MultiCycleCPU datapath
// through IF / ID / EXE / MEM / WB.
// Ports:
//   CLK, Reset          - clock, synchronous active-high reset
//   opcode, zero, sign  - IR[31:26] and ALU flags
//   state               - current FSM state (trace)
//   PCWre .. ALUOp      - datapath enables and mux selects (combinational)
// The state register and next-state logic live here; the control word comes
// from mcpu_decode. Architectural write enables are masked while Reset is
// high so a reset landing mid-instruction commits nothing.
module multicycle_control_unit
  import mcpu_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           sign,
  output logic [STW-1:0] state,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           RegWre,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic           DBDataSrc,
  output logic           WrRegDSrc,
  output logic           mRD,
  output logic           mWR,
  output logic           ExtSel,
  output logic [1:0]     RegDst,
  output logic [1:0]     PCSrc,
  output logic [2:0]     ALUOp
);

  state_t state_q;
  state_t state_n;
  ctrl_t  ctrl;

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = S_IF;
    case (state_q)
      S_IF:    state_n = S_ID;
      S_ID: begin
        // halt and undefined opcodes park in ID until Reset.
        if (op_jump(opcode))                              state_n = S_IF;
        else if (!op_defined(opcode) || opcode == OP_HALT) state_n = S_ID;
        else if (op_branch(opcode))                       state_n = S_EXE_B;
        else if (op_mem(opcode))                          state_n = S_EXE_M;
        else                                              state_n = S_EXE_R;
      end
      S_EXE_R: state_n = S_WB_R;
      S_WB_R:  state_n = S_IF;
      S_EXE_B: state_n = S_IF;
      S_EXE_M: state_n = S_MEM;
      S_MEM:   state_n = (opcode == OP_LW) ? S_WB_M : S_IF;
      S_WB_M:  state_n = S_IF;
      default: state_n = S_IF;
    endcase
  end

  mcpu_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .sign   (sign),
    .ctrl   (ctrl)
  );

  assign state     = state_q;
  assign PCWre     = ctrl.pcwre  & ~Reset;
  assign RegWre    = ctrl.regwre & ~Reset;
  assign mWR       = ctrl.mwr    & ~Reset;
  assign IRWre     = ctrl.irwre;
  assign InsMemRW  = ctrl.insmemrw;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign DBDataSrc = ctrl.dbdatasrc;
  assign WrRegDSrc = ctrl.wrregdsrc;
  assign mRD       = ctrl.mrd;
  assign ExtSel    = ctrl.extsel;
  assign RegDst    = ctrl.regdst;
  assign PCSrc     = ctrl.pcsrc;
  assign ALUOp     = ctrl.aluop;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB;
  logic       DBDataSrc, WrRegDSrc, mRD, mWR, ExtSel;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.OPW(6), .STW(3)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR),
    .ExtSel(ExtSel), .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, checks happen 3ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    Reset = 1'b1; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
    tick(); tick(); settle();
    check("rst_state", {5'b0, state}, 8'h0);
    check("rst_pcwre", {7'b0, PCWre}, 8'h0);

    // Post-reset IF
    Reset = 1'b0; settle();
    check("if_state",  {5'b0, state}, 8'h0);
    check("if_irwre",  {7'b0, IRWre}, 8'h1);
    check("if_insmem", {7'b0, InsMemRW}, 8'h1);
    check("if_pcwre",  {7'b0, PCWre}, 8'h0);
    check("if_regwre", {7'b0, RegWre}, 8'h0);

    // add: 000,001,110,111,000
    tick(); settle(); check("add_id", {5'b0, state}, 8'h1);
    check("add_id_pcwre", {7'b0, PCWre}, 8'h0);
    tick(); settle(); check("add_exe", {5'b0, state}, 8'h6);
    check("add_exe_aluop", {5'b0, ALUOp}, 8'h0);
    check("add_exe_regwre", {7'b0, RegWre}, 8'h0);
    tick(); settle(); check("add_wb", {5'b0, state}, 8'h7);
    check("add_wb_regwre", {7'b0, RegWre}, 8'h1);
    check("add_wb_regdst", {6'b0, RegDst}, 8'h2);
    check("add_wb_pcwre", {7'b0, PCWre}, 8'h1);
    check("add_wb_wrsrc", {7'b0, WrRegDSrc}, 8'h1);
    tick(); settle(); check("add_done", {5'b0, state}, 8'h0);

    // lw: 000,001,010,011,100
    opcode = 6'b110001;
    tick(); settle(); check("lw_id", {5'b0, state}, 8'h1);
    tick(); settle(); check("lw_exe", {5'b0, state}, 8'h2);
    check("lw_exe_srcb", {7'b0, ALUSrcB}, 8'h1);
    check("lw_exe_ext", {7'b0, ExtSel}, 8'h1);
    check("lw_exe_aluop", {5'b0, ALUOp}, 8'h0);
    tick(); settle(); check("lw_mem", {5'b0, state}, 8'h3);
    check("lw_mem_mrd", {7'b0, mRD}, 8'h1);
    check("lw_mem_db", {7'b0, DBDataSrc}, 8'h1);
    check("lw_mem_pcwre", {7'b0, PCWre}, 8'h0);
    check("lw_mem_mwr", {7'b0, mWR}, 8'h0);
    tick(); settle(); check("lw_wb", {5'b0, state}, 8'h4);
    check("lw_wb_regwre", {7'b0, RegWre}, 8'h1);
    check("lw_wb_regdst", {6'b0, RegDst}, 8'h1);
    check("lw_wb_db", {7'b0, DBDataSrc}, 8'h1);
    check("lw_wb_pcwre", {7'b0, PCWre}, 8'h1);
    tick(); settle(); check("lw_done", {5'b0, state}, 8'h0);

    // sw: 000,001,010,011
    opcode = 6'b110000;
    tick(); tick(); settle(); check("sw_exe", {5'b0, state}, 8'h2);
    tick(); settle(); check("sw_mem", {5'b0, state}, 8'h3);
    check("sw_mem_mwr", {7'b0, mWR}, 8'h1);
    check("sw_mem_mrd", {7'b0, mRD}, 8'h0);
    check("sw_mem_pcwre", {7'b0, PCWre}, 8'h1);
    check("sw_mem_regwre", {7'b0, RegWre}, 8'h0);
    tick(); settle(); check("sw_done", {5'b0, state}, 8'h0);

    // beq taken then not taken within sEXE_B
    opcode = 6'b110100; zero = 1'b1;
    tick(); settle(); check("beq_id", {5'b0, state}, 8'h1);
    tick(); settle(); check("beq_exe", {5'b0, state}, 8'h5);
    check("beq_t_pcsrc", {6'b0, PCSrc}, 8'h1);
    check("beq_t_pcwre", {7'b0, PCWre}, 8'h1);
    check("beq_aluop", {5'b0, ALUOp}, 8'h1);
    zero = 1'b0; settle();
    check("beq_nt_pcsrc", {6'b0, PCSrc}, 8'h0);
    check("beq_nt_pcwre", {7'b0, PCWre}, 8'h1);
    tick(); settle(); check("beq_done", {5'b0, state}, 8'h0);

    // bne with zero=0 (taken)
    opcode = 6'b110101; zero = 1'b0;
    tick(); tick(); settle(); check("bne_exe", {5'b0, state}, 8'h5);
    check("bne_t_pcsrc", {6'b0, PCSrc}, 8'h1);
    zero = 1'b1; settle();
    check("bne_nt_pcsrc", {6'b0, PCSrc}, 8'h0);
    tick();

    // bltz with sign=1 (taken)
    opcode = 6'b110110; zero = 1'b0; sign = 1'b1;
    tick(); tick(); settle(); check("bltz_exe", {5'b0, state}, 8'h5);
    check("bltz_t_pcsrc", {6'b0, PCSrc}, 8'h1);
    sign = 1'b0; settle();
    check("bltz_nt_pcsrc", {6'b0, PCSrc}, 8'h0);
    tick(); settle(); check("bltz_done", {5'b0, state}, 8'h0);

    // jal completes in ID
    opcode = 6'b111010;
    tick(); settle(); check("jal_id", {5'b0, state}, 8'h1);
    check("jal_regwre", {7'b0, RegWre}, 8'h1);
    check("jal_regdst", {6'b0, RegDst}, 8'h0);
    check("jal_wrsrc", {7'b0, WrRegDSrc}, 8'h0);
    check("jal_pcsrc", {6'b0, PCSrc}, 8'h3);
    check("jal_pcwre", {7'b0, PCWre}, 8'h1);
    tick(); settle(); check("jal_done", {5'b0, state}, 8'h0);

    // jr
    opcode = 6'b111001;
    tick(); settle(); check("jr_pcsrc", {6'b0, PCSrc}, 8'h2);
    check("jr_pcwre", {7'b0, PCWre}, 8'h1);
    check("jr_regwre", {7'b0, RegWre}, 8'h0);
    tick(); settle(); check("jr_done", {5'b0, state}, 8'h0);

    // sll: shamt source, rd destination
    opcode = 6'b011000;
    tick(); tick(); settle(); check("sll_exe", {5'b0, state}, 8'h6);
    check("sll_srca", {7'b0, ALUSrcA}, 8'h1);
    check("sll_aluop", {5'b0, ALUOp}, 8'h2);
    tick(); settle(); check("sll_regdst", {6'b0, RegDst}, 8'h2);
    check("sll_wb_aluop", {5'b0, ALUOp}, 8'h2);
    tick();

    // ori: zero-extended immediate, rt destination
    opcode = 6'b010010;
    tick(); tick(); settle(); check("ori_exe", {5'b0, state}, 8'h6);
    check("ori_ext", {7'b0, ExtSel}, 8'h0);
    check("ori_srcb", {7'b0, ALUSrcB}, 8'h1);
    check("ori_aluop", {5'b0, ALUOp}, 8'h3);
    tick(); settle(); check("ori_regdst", {6'b0, RegDst}, 8'h1);
    tick();

    // undefined opcode parks in ID like halt
    opcode = 6'b101010;
    tick(); tick(); tick(); settle();
    check("undef_state", {5'b0, state}, 8'h1);
    check("undef_pcwre", {7'b0, PCWre}, 8'h0);
    Reset = 1'b1; tick(); settle();
    check("undef_rst", {5'b0, state}, 8'h0);
    Reset = 1'b0;

    // Reset asserted during sWB_R of add
    opcode = 6'b000000;
    tick(); tick(); tick(); settle();
    check("rwb_state", {5'b0, state}, 8'h7);
    Reset = 1'b1; settle();
    check("rwb_regwre", {7'b0, RegWre}, 8'h0);
    check("rwb_pcwre", {7'b0, PCWre}, 8'h0);
    tick(); settle();
    check("rwb_after", {5'b0, state}, 8'h0);
    check("rwb_after_regwre", {7'b0, RegWre}, 8'h0);
    Reset = 1'b0;

    // halt holds in ID for 10 cycles
    opcode = 6'b111111;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      check("halt_state", {5'b0, state}, 8'h1);
      check("halt_pcwre", {7'b0, PCWre}, 8'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
